// File: rtl/t02_wishbone_manager.sv
// t02_wishbone_manager
// Turns single-word RAM requests from the memory-request stage into
// Wishbone classic bus cycles. Read data is returned on ramload. A watchdog
// aborts any bus cycle that the slave never acknowledges.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no bus cycle; sample Wen (priority) / Ren and latch request
// READ  | read bus cycle active, waiting for ACK_I or timeout
// WRITE | write bus cycle active, waiting for ACK_I or timeout
// DONE  | completion cycle: busy_o low, err_o valid, requests ignored

module t02_wishbone_manager #(
  parameter int unsigned  TIMEOUT_CYCLES = 16,
  parameter logic [31:0]  ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The counter holds the number of unacknowledged cycles already completed,
  // so the last permitted STB cycle is the one where it equals limit-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [7:0]  tmo_cnt;
  logic        timeout_hit;

  assign timeout_hit = (tmo_cnt == TMO_LAST);

  // Address and data come from the latched request; forced to zero outside
  // a bus cycle so the interconnect never sees stale values.
  assign ADR_O = CYC_O ? addr_q : 32'h0;
  assign DAT_O = CYC_O ? data_q : 32'h0;

  // Busy: combinational in IDLE so the requester is stalled in its request
  // cycle; always high during the bus cycle and low in DONE.
  always_comb begin
    busy_o = 1'b0;
    case (state)
      IDLE:         busy_o = Ren | Wen;
      READ, WRITE:  busy_o = 1'b1;
      DONE:         busy_o = 1'b0;
      default:      busy_o = 1'b0;
    endcase
  end

  // Main sequencer: request latch, bus strobes, watchdog, read data and error.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      tmo_cnt <= 8'h0;
      ramload <= 32'h0;
      err_o   <= 1'b0;
      SEL_O   <= 4'h0;
      WE_O    <= 1'b0;
      STB_O   <= 1'b0;
      CYC_O   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_o <= 1'b0;
          if (Wen) begin
            addr_q  <= ramaddr & 32'hFFFF_FFFC;
            data_q  <= ramstore;
            tmo_cnt <= 8'h0;
            SEL_O   <= 4'hF;
            WE_O    <= 1'b1;
            STB_O   <= 1'b1;
            CYC_O   <= 1'b1;
            state   <= WRITE;
          end else if (Ren) begin
            addr_q  <= ramaddr & 32'hFFFF_FFFC;
            tmo_cnt <= 8'h0;
            SEL_O   <= 4'hF;
            WE_O    <= 1'b0;
            STB_O   <= 1'b1;
            CYC_O   <= 1'b1;
            state   <= READ;
          end
        end

        READ, WRITE: begin
          // An ack in the final permitted cycle still wins over the timeout.
          if (ACK_I || timeout_hit) begin
            if (state == READ) begin
              ramload <= ACK_I ? DAT_I : ERR_DATA;
            end
            err_o <= ~ACK_I;
            SEL_O <= 4'h0;
            WE_O  <= 1'b0;
            STB_O <= 1'b0;
            CYC_O <= 1'b0;
            state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        DONE: begin
          err_o <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
